// File: rtl/redux_pkg.sv
// Shared definitions for the Redux-V execution controller: opcodes, FSM
// state encoding and instruction field positions.
package redux_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int NREGS_DEF  = 4;

    localparam logic [3:0] OP_NOT = 4'd0;
    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_SLR = 4'd6;
    localparam logic [3:0] OP_SRR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_ROL = 4'd9;
    localparam logic [3:0] OP_LDI = 4'd15;

    // Instruction byte layout: [7:4] opcode, [3:2] ra, [1:0] rb.
    localparam int OP_HI = 7;
    localparam int OP_LO = 4;
    localparam int RA_HI = 3;
    localparam int RA_LO = 2;
    localparam int RB_HI = 1;
    localparam int RB_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_WB   = 3'd2,
        S_IMM  = 3'd3,
        S_ILL  = 3'd4
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op <= OP_ROL;
    endfunction

endpackage

// File: rtl/redux_regfile.sv
// Register file: two combinational operand read ports, one combinational
// debug read port and a single synchronous write port, reset to zero.
module redux_regfile
    import redux_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  NREGS  = NREGS_DEF,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     rd_a_addr,
    output logic [DATA_W-1:0] rd_a_data,
    input  logic [AW-1:0]     rd_b_addr,
    output logic [DATA_W-1:0] rd_b_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // No write-through: a read of the register being written sees the old value.
    assign rd_a_data = regs[rd_a_addr];
    assign rd_b_data = regs[rd_b_addr];
    assign dbg_data  = regs[dbg_addr];

endmodule

// File: rtl/redux_exec_ctrl.sv
// Redux-V instruction issue: accepts instruction bytes, drives the external
// ULA from the register file and writes its result back into R[ra].
module redux_exec_ctrl
    import redux_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  NREGS  = NREGS_DEF,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [7:0]        instr,
    output logic              instr_ready,
    output logic [DATA_W-1:0] ula_a,
    output logic [DATA_W-1:0] ula_b,
    output logic [3:0]        ula_select,
    input  logic [DATA_W-1:0] ula_s,
    output logic              busy,
    output logic              done,
    output logic              zero,
    output logic              illegal,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state;
    logic [AW-1:0]     ra_q;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              accept;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        instr_op;
    logic [AW-1:0]     instr_ra;
    logic [AW-1:0]     instr_rb;

    assign instr_op = instr[OP_HI:OP_LO];
    assign instr_ra = instr[RA_HI:RA_LO];
    assign instr_rb = instr[RB_HI:RB_LO];

    // valid/ready: a byte moves on a rising edge where both are high; the
    // source must hold instr stable while instr_valid is high and not ready.
    assign instr_ready = ((state == S_IDLE) || (state == S_IMM)) && !rst;
    assign accept      = instr_valid && instr_ready;
    assign busy        = (state != S_IDLE);

    assign wr_en   = (state == S_WB) || ((state == S_IMM) && accept);
    assign wr_data = (state == S_WB) ? res_q : instr;

    redux_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_a_addr (instr_ra),
        .rd_a_data (rd_a),
        .rd_b_addr (instr_rb),
        .rd_b_data (rd_b),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wr_en     (wr_en),
        .wr_addr   (ra_q),
        .wr_data   (wr_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ra_q       <= '0;
            res_q      <= '0;
            ula_a      <= '0;
            ula_b      <= '0;
            ula_select <= '0;
            done       <= 1'b0;
            illegal    <= 1'b0;
            zero       <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        ra_q <= instr_ra;
                        if (is_alu_op(instr_op)) begin
                            // Operands are captured at issue so the ULA ports hold steady outside EXEC.
                            ula_a      <= rd_a;
                            ula_b      <= rd_b;
                            ula_select <= instr_op;
                            state      <= S_EXEC;
                        end else if (instr_op == OP_LDI) begin
                            state <= S_IMM;
                        end else begin
                            state <= S_ILL;
                        end
                    end
                end
                S_EXEC: begin
                    res_q <= ula_s;
                    state <= S_WB;
                end
                S_WB: begin
                    zero  <= (res_q == '0);
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                S_IMM: begin
                    if (accept) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_ILL: begin
                    done    <= 1'b1;
                    illegal <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_redux_exec_ctrl.sv
// Bench for redux_exec_ctrl: retire-latency model plus directed instruction sequences.
module tb_redux_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       instr_ready;
    logic [7:0] ula_a;
    logic [7:0] ula_b;
    logic [3:0] ula_select;
    logic [7:0] ula_s;
    logic       busy;
    logic       done;
    logic       zero;
    logic       illegal;
    logic [1:0] dbg_addr = 2'd0;
    logic [7:0] dbg_data;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    redux_exec_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .ula_a       (ula_a),
        .ula_b       (ula_b),
        .ula_select  (ula_select),
        .ula_s       (ula_s),
        .busy        (busy),
        .done        (done),
        .zero        (zero),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Stand-in for the external ULA.
    function automatic logic [7:0] ula_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] sel);
        logic [15:0] d;
        logic [15:0] p;
        int sh;
        d  = {a, a};
        sh = int'(b[2:0]);
        p  = 16'(a) * 16'(b);
        case (sel)
            4'd0: return ~b;
            4'd1: return a & b;
            4'd2: return a | b;
            4'd3: return a ^ b;
            4'd4: return 8'(a + b);
            4'd5: return 8'(a - b);
            4'd6: return (b >= 8'd8) ? 8'h00 : (a >> b);
            4'd7: return d[(7 + sh) -: 8];
            4'd8: return p[7:0];
            4'd9: return d[(15 - sh) -: 8];
            default: return 8'h00;
        endcase
    endfunction

    assign ula_s = ula_fn(ula_a, ula_b, ula_select);

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each accepted instruction retires a fixed number of edges later.
    logic [7:0] m_regs [4];
    logic       m_zero = 1'b0;
    logic       m_done = 1'b0;
    logic       m_ill  = 1'b0;
    logic [7:0] e_a = 8'h00;
    logic [7:0] e_b = 8'h00;
    logic [3:0] e_sel = 4'h0;
    logic [1:0] m_ra = 2'd0;
    logic [7:0] m_res = 8'h00;
    int         alu_left = 0;
    int         ill_left = 0;
    bit         in_imm = 1'b0;
    int         acc_cnt = 0;
    bit         chk_en = 1'b0;
    bit         dbg_hold = 1'b0;
    int         done_cnt = 0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
            m_zero = 1'b0; m_done = 1'b0; m_ill = 1'b0;
            e_a = 8'h00; e_b = 8'h00; e_sel = 4'h0;
            alu_left = 0; ill_left = 0; in_imm = 1'b0;
            chk_en = 1'b1;
        end else begin
            m_done = 1'b0;
            m_ill  = 1'b0;
            if (alu_left > 0) begin
                alu_left--;
                if (alu_left == 0) begin
                    m_regs[m_ra] = m_res;
                    m_zero = (m_res == 8'h00);
                    m_done = 1'b1;
                end
            end else if (ill_left > 0) begin
                ill_left = 0;
                m_done = 1'b1;
                m_ill  = 1'b1;
            end else if (instr_valid) begin
                acc_cnt++;
                if (in_imm) begin
                    m_regs[m_ra] = instr;
                    in_imm = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_ra = instr[3:2];
                    if (instr[7:4] <= 4'd9) begin
                        e_a   = m_regs[instr[3:2]];
                        e_b   = m_regs[instr[1:0]];
                        e_sel = instr[7:4];
                        m_res = ula_fn(e_a, e_b, e_sel);
                        alu_left = 2;
                    end else if (instr[7:4] == 4'd15) begin
                        in_imm = 1'b1;
                    end else begin
                        ill_left = 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk1("ready", instr_ready, (alu_left == 0) && (ill_left == 0) && !rst);
            chk1("busy", busy, (alu_left > 0) || (ill_left > 0) || in_imm);
            chk1("done", done, m_done);
            chk1("illegal", illegal, m_ill);
            chk1("zero", zero, m_zero);
            chk8("ula_a", ula_a, e_a);
            chk8("ula_b", ula_b, e_b);
            chk8("ula_select", {4'h0, ula_select}, {4'h0, e_sel});
            chk8("dbg_data", dbg_data, m_regs[dbg_addr]);
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en && done === 1'b1) done_cnt++;
    end

    // Sweep the debug port so every register is compared over time.
    initial forever begin
        @(posedge clk);
        #2;
        if (!dbg_hold) dbg_addr = dbg_addr + 2'd1;
    end

    task automatic send(input logic [7:0] b);
        int start;
        int n;
        instr = b;
        instr_valid = 1'b1;
        start = acc_cnt;
        n = 0;
        while (acc_cnt == start && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (acc_cnt == start) begin
            total++;
            bad++;
            $display("FAIL send_timeout: byte %02h not accepted within 40 cycles", b);
        end
        instr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [1:0] a, input logic [7:0] exp, input string nm);
        @(negedge clk);
        #2;
        dbg_hold = 1'b1;
        dbg_addr = a;
        #1;
        chk8(nm, dbg_data, exp);
        dbg_hold = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        rst = 1'b1;
        idle(2);
        chk1("rst_zero", zero, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk8("rst_ula_a", ula_a, 8'h00);
        rst = 1'b0;
        peek(2'd0, 8'h00, "rst_r0");

        // LDI R0=0x47, LDI R1=0x02, ADD R0,R1.
        send(8'hF0); send(8'h47); send(8'hF4); send(8'h02);
        send(8'h41);
        chk8("add_ula_a", ula_a, 8'h47);
        chk8("add_ula_b", ula_b, 8'h02);
        chk8("add_sel", {4'h0, ula_select}, 8'h04);
        chk1("add_ready_exec", instr_ready, 1'b0);
        idle(1);
        chk1("add_done_wb", done, 1'b0);
        idle(1);
        chk1("add_done", done, 1'b1);
        chk1("add_zero", zero, 1'b0);
        peek(2'd0, 8'h49, "add_r0");

        // SUB R2,R3 with equal values, then OR clears zero.
        send(8'hF8); send(8'h47); send(8'hFC); send(8'h47);
        send(8'h5B);
        idle(2);
        chk1("sub_zero", zero, 1'b1);
        peek(2'd2, 8'h00, "sub_r2");
        send(8'h2B);
        idle(2);
        chk1("or_zero", zero, 1'b0);
        peek(2'd2, 8'h47, "or_r2");

        // ROL R0 by R1=0x0C.
        send(8'hF0); send(8'h47); send(8'hF4); send(8'h0C);
        send(8'h91);
        chk8("rol_sel", {4'h0, ula_select}, 8'h09);
        chk8("rol_ula_b", ula_b, 8'h0C);
        idle(2);
        peek(2'd0, 8'h74, "rol_r0");

        // Reserved opcode with zero set beforehand.
        send(8'h5B);
        idle(2);
        send(8'hA5);
        chk1("ill_ready", instr_ready, 1'b0);
        chk1("ill_early", illegal, 1'b0);
        idle(1);
        chk1("ill_done", done, 1'b1);
        chk1("ill_pulse", illegal, 1'b1);
        chk1("ill_zero", zero, 1'b1);
        idle(1);
        chk1("ill_pulse_end", illegal, 1'b0);
        peek(2'd1, 8'h0C, "ill_r1");

        // Back-to-back stream with valid held; R0=74 R1=0C R2=00 R3=47.
        d0 = done_cnt;
        send(8'h13); send(8'h87); send(8'h06); send(8'h6C);
        send(8'h72); send(8'hC0); send(8'h31);
        idle(2);
        peek(2'd0, 8'hBB, "b2b_r0");
        peek(2'd1, 8'hFF, "b2b_r1");
        peek(2'd3, 8'h00, "b2b_r3");
        chkn("b2b_done_count", done_cnt - d0, 7);

        // Reset during EXEC of ADD aborts it.
        send(8'hF4); send(8'h05);
        idle(2);
        d0 = done_cnt;
        send(8'h41);
        rst = 1'b1;
        idle(1);
        chk1("rst_mid_done", done, 1'b0);
        chk1("rst_mid_busy", busy, 1'b0);
        chk8("rst_mid_ula_b", ula_b, 8'h00);
        chk1("rst_mid_ready", instr_ready, 1'b0);
        rst = 1'b0;
        idle(2);
        peek(2'd0, 8'h00, "rst_mid_r0");
        chkn("rst_mid_no_done", done_cnt - d0, 0);

        // Immediate byte delayed while zero is set.
        send(8'h5A);
        idle(2);
        send(8'hF8);
        for (int i = 0; i < 3; i++) begin
            chk1("imm_busy", busy, 1'b1);
            chk1("imm_ready", instr_ready, 1'b1);
            idle(1);
        end
        send(8'hFF);
        chk1("imm_done", done, 1'b1);
        chk1("imm_zero", zero, 1'b1);
        peek(2'd2, 8'hFF, "imm_r2");

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
